// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / flag-use stalls and taken-branch flush.
// Latency: control outputs are combinational (0 cycles); hz_state is the registered view one edge later.
// Backpressure: stalls the front end by dropping PCWrite/IFIDWrite and bubbling ID/EX; no upstream handshake.
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating stall_cnt performance counter port.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rn_id,
   input  logic [4:0]  Rm_id,
   input  logic        useRm_id,
   input  logic        CondBr_id,
   input  logic        RegWrite_ex,
   input  logic        MemToReg_ex,
   input  logic        flagWrite_ex,
   input  logic [4:0]  Rd_ex,
   input  logic        BrTaken_ex,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFID_flush,
   output logic        IDEX_bubble,
   output logic [1:0]  hz_state
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } hz_state_e;

   // XZR reads as zero and is never really written, so it can't carry a dependency.
   localparam logic [4:0] XZR = 5'd31;

   hz_state_e  state_q, state_d;
   logic [1:0] stall_run_q, stall_run_d;
   logic       load_use;
   logic       flag_use;
   logic       hazard;

   // Hazard detection from the current ID and EX operands only; FSM state never masks it.
   always_comb begin
      load_use = MemToReg_ex & RegWrite_ex & (Rd_ex != XZR) &
                 ((Rd_ex == Rn_id) | (useRm_id & (Rd_ex == Rm_id)));
      flag_use = CondBr_id & flagWrite_ex;
      hazard   = load_use | flag_use;
   end

   // Control outputs and next state; a taken branch wins over any stall, reset wins over both.
   always_comb begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_bubble = 1'b0;
      state_d     = ST_RUN;
      if (reset) begin
         state_d = ST_RUN;
      end else if (BrTaken_ex) begin
         // Squash the wrong-path instruction in IF/ID and the one entering EX.
         IFID_flush  = 1'b1;
         IDEX_bubble = 1'b1;
         state_d     = ST_FLUSH;
      end else if (hazard) begin
         // Hold PC and IF/ID so the consumer re-decodes once the producer result is ready.
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
         IDEX_bubble = 1'b1;
         state_d     = ST_STALL;
      end
   end

   // Length of the current run of STALL states, saturating at 3.
   always_comb begin
      stall_run_d = 2'd0;
      if (!reset && state_d == ST_STALL) begin
         stall_run_d = (stall_run_q == 2'd3) ? 2'd3 : stall_run_q + 2'd1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         stall_run_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         stall_run_q <= stall_run_d;
      end
   end

   assign hz_state = state_q;

   // A producer is at most one cycle ahead, so a third back-to-back stall means the pipeline is wedged.
   stall_run_limit: assert property (@(posedge clk) disable iff (reset) stall_run_q <= 2'd2);

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count cycles where the PC is held, saturating instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (reset) begin
         stall_cnt_d = 32'd0;
      end else if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Performance counter register.
   always_ff @(posedge clk) begin
      stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, XZR, Rm gating, branch priority, flag-use.
// Latency: control outputs checked 1 time unit after input change; hz_state checked 1 unit after the edge.
// Backpressure: none; stimulus is a fixed directed sequence with no DUT waits.
module tb_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  Rn_id;
   logic [4:0]  Rm_id;
   logic        useRm_id;
   logic        CondBr_id;
   logic        RegWrite_ex;
   logic        MemToReg_ex;
   logic        flagWrite_ex;
   logic [4:0]  Rd_ex;
   logic        BrTaken_ex;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFID_flush;
   logic        IDEX_bubble;
   logic [1:0]  hz_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_tests;
   int n_fail;

   hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .Rn_id        (Rn_id),
      .Rm_id        (Rm_id),
      .useRm_id     (useRm_id),
      .CondBr_id    (CondBr_id),
      .RegWrite_ex  (RegWrite_ex),
      .MemToReg_ex  (MemToReg_ex),
      .flagWrite_ex (flagWrite_ex),
      .Rd_ex        (Rd_ex),
      .BrTaken_ex   (BrTaken_ex),
      .PCWrite      (PCWrite),
      .IFIDWrite    (IFIDWrite),
      .IFID_flush   (IFID_flush),
      .IDEX_bubble  (IDEX_bubble),
      .hz_state     (hz_state)
`ifdef HAZARD_PERF_CNT_EN
      ,.stall_cnt   (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Compare the four control outputs packed as {PCWrite, IFIDWrite, IFID_flush, IDEX_bubble}.
   task automatic check_ctl(input string tag, input logic [3:0] exp);
      #1;
      check(tag, {28'd0, PCWrite, IFIDWrite, IFID_flush, IDEX_bubble}, {28'd0, exp});
   endtask

   task automatic check_state(input string tag, input logic [1:0] exp);
      check(tag, {30'd0, hz_state}, {30'd0, exp});
   endtask

   task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef HAZARD_PERF_CNT_EN
      check(tag, stall_cnt, exp);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic userm,
                         input logic condbr, input logic rw, input logic m2r, input logic fw,
                         input logic [4:0] rd, input logic br);
      Rn_id        = rn;
      Rm_id        = rm;
      useRm_id     = userm;
      CondBr_id    = condbr;
      RegWrite_ex  = rw;
      MemToReg_ex  = m2r;
      flagWrite_ex = fw;
      Rd_ex        = rd;
      BrTaken_ex   = br;
   endtask

   task automatic idle();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      idle();
      step();

      // Reset overrides a live load-use hazard.
      set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
      check_ctl("reset_ctl", 4'b1100);
      step();
      check_state("reset_state", 2'b00);
      check_cnt("reset_cnt", 32'd0);

      // Load-use on Rn: stall, STALL state, then back to RUN.
      reset = 1'b0;
      check_ctl("lu_rn_ctl", 4'b0001);
      step();
      check_state("lu_rn_state", 2'b01);
      check_cnt("lu_rn_cnt", 32'd1);
      idle();
      check_ctl("lu_clear_ctl", 4'b1100);
      step();
      check_state("lu_clear_state", 2'b00);
      check_cnt("lu_clear_cnt", 32'd1);

      // XZR never produces load-use.
      set_in(5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd31, 1'b0);
      check_ctl("xzr_ctl", 4'b1100);
      step();
      check_state("xzr_state", 2'b00);

      // Load without RegWrite is not a producer.
      set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);
      check_ctl("norw_ctl", 4'b1100);

      // Non-load write to the same register is forwarded, no stall.
      set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0);
      check_ctl("alu_ctl", 4'b1100);

      // Rm match only counts when the instruction reads Rm.
      set_in(5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);
      check_ctl("rm_unused_ctl", 4'b1100);
      useRm_id = 1'b1;
      check_ctl("rm_used_ctl", 4'b0001);
      step();
      check_state("rm_used_state", 2'b01);
      check_cnt("rm_used_cnt", 32'd2);
      idle();
      step();
      check_state("rm_clear_state", 2'b00);

      // Taken branch overrides load-use: flush, FLUSH state, then RUN.
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1);
      check_ctl("br_ctl", 4'b1111);
      step();
      check_state("br_state", 2'b10);
      check_cnt("br_cnt", 32'd2);
      idle();
      check_ctl("br_clear_ctl", 4'b1100);
      step();
      check_state("br_clear_state", 2'b00);

      // Hazards are still evaluated while in FLUSH.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      step();
      check_state("br2_state", 2'b10);
      set_in(5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
      check_ctl("flush_lu_ctl", 4'b0001);
      step();
      check_state("flush_lu_state", 2'b01);
      check_cnt("flush_lu_cnt", 32'd3);
      idle();
      step();
      check_state("flush_lu_clear", 2'b00);

      // Flag-use needs both a conditional branch and a flag writer.
      set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      check_ctl("cb_nofw_ctl", 4'b1100);
      flagWrite_ex = 1'b1;
      check_ctl("flag_ctl", 4'b0001);
      step();
      check_state("flag_state", 2'b01);
      check_cnt("flag_cnt", 32'd4);

      // Reset while in STALL with the hazard still present.
      reset = 1'b1;
      check_ctl("rst_stall_ctl", 4'b1100);
      step();
      check_state("rst_stall_state", 2'b00);
      check_cnt("rst_stall_cnt", 32'd0);
      reset = 1'b0;
      idle();
      check_ctl("post_rst_ctl", 4'b1100);
      step();
      check_state("post_rst_state", 2'b00);
      check_cnt("post_rst_cnt", 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: Rn_id  input  5  first source register of the instruction in ID.
REQ-004: Rm_id  input  5  second source register of the instruction in ID.
REQ-005: useRm_id  input  1  ID instruction reads Rm_id (Rm, or Rt for a store).
REQ-006: CondBr_id  input  1  ID instruction is B.cond and reads flags.
REQ-007: RegWrite_ex  input  1  RegWrite control leaving ID/EX.
REQ-008: MemToReg_ex  input  1  MemToReg control leaving ID/EX; 1 marks a load.
REQ-009: flagWrite_ex  input  1  flagWrite control leaving ID/EX.
REQ-010: Rd_ex  input  5  destination register leaving ID/EX.
REQ-011: BrTaken_ex  input  1  branch resolved taken in EX this cycle.
REQ-012: PCWrite  output  1  1 = PC register loads this cycle.
REQ-013: IFIDWrite  output  1  1 = IF/ID register loads this cycle.
REQ-014: IFID_flush  output  1  1 = IF/ID loads a NOP this cycle.
REQ-015: IDEX_bubble  output  1  1 = ID/EX control inputs forced to 0 this cycle.
REQ-016: hz_state  output  2  registered FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-017: stall_cnt  output  32  stall-cycle count; present only with HAZARD_PERF_CNT_EN.

Function
REQ-018: The block SHALL compute loadUse = MemToReg_ex & RegWrite_ex & (Rd_ex != 31) & ((Rd_ex == Rn_id) | (useRm_id & (Rd_ex == Rm_id))).
REQ-019: The block SHALL compute flagUse = CondBr_id & flagWrite_ex.
REQ-020: The block SHALL drive all four control outputs combinationally in the same cycle as the condition, with zero-cycle latency.
REQ-021: In the absence of any hazard, the outputs SHALL be PCWrite=1, IFIDWrite=1, IFID_flush=0, IDEX_bubble=0.
REQ-022: If BrTaken_ex=1, the outputs SHALL be PCWrite=1, IFIDWrite=1, IFID_flush=1, IDEX_bubble=1, and next state SHALL be FLUSH.
REQ-023: BrTaken_ex SHALL override loadUse and flagUse in the same cycle, and no stall SHALL be asserted in that cycle.
REQ-024: If (loadUse | flagUse) and !BrTaken_ex, the outputs SHALL be PCWrite=0, IFIDWrite=0, IFID_flush=0, IDEX_bubble=1, and next state SHALL be STALL.
REQ-025: STALL SHALL return to RUN after one cycle unless a new hazard is evaluated true; hazard evaluation SHALL always use current inputs.
REQ-026: FLUSH SHALL return to RUN after one cycle, and hazards SHALL be evaluated normally while in FLUSH.
REQ-027: Register 31 (XZR) SHALL never produce loadUse.
REQ-028: More than 2 consecutive STALL cycles SHALL be reported by simulation assertion as a protocol error and SHALL NOT alter outputs.

Reset
REQ-029: While reset=1, the block SHALL force hz_state=RUN, PCWrite=1, IFIDWrite=1, IFID_flush=0, IDEX_bubble=0, and stall_cnt=0.
REQ-030: A reset asserted during STALL or FLUSH SHALL abandon that state at the next edge with no residual stall.

Configuration
REQ-031: With HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 on each clock edge where PCWrite=0 and reset=0, saturating at 0xFFFFFFFF.
REQ-032: Without HAZARD_PERF_CNT_EN, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033: Load with Rd_ex=5, MemToReg_ex=1, RegWrite_ex=1, and Rn_id=5 -> PCWrite=0, IFIDWrite=0, IDEX_bubble=1; hz_state=01 next cycle; RUN after the hazard clears.
REQ-034: Same as REQ-033 but Rd_ex=31 and Rn_id=31 -> no stall, outputs 1/1/0/0.
REQ-035: Rd_ex=7, Rm_id=7: with useRm_id=0 -> no stall; with useRm_id=1 -> stall.
REQ-036: loadUse=1 and BrTaken_ex=1 together -> PCWrite=1, IFID_flush=1, IDEX_bubble=1; hz_state=10, then 00.
REQ-037: CondBr_id=1 and flagWrite_ex=1 -> one stall cycle, stall_cnt 0 -> 1; reset asserted in STALL -> hz_state=00 and stall_cnt=0 next edge.
